// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, baud divisor helper and parameter checks
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Clocks per bit, rounded to nearest.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  // True when every transmitter parameter is inside its legal range.
  function automatic bit params_legal(input int clk_hz, input int baud, input int data_bits,
                                      input int stop_bits, input int fifo_depth,
                                      input int parity_odd);
    bit ok;
    ok = 1'b1;
    if (baud <= 0 || clk_hz <= 0) ok = 1'b0;
    else if (baud_div(clk_hz, baud) < 2) ok = 1'b0;
    if (data_bits < 5 || data_bits > 9) ok = 1'b0;
    if (stop_bits < 1 || stop_bits > 2) ok = 1'b0;
    if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0) ok = 1'b0;
    if (parity_odd != 0 && parity_odd != 1) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with occupancy count, full and empty flags
module uart_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     push,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter; optional parity bit via UART_TX_PARITY_EN
module uart_tx_fifo #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          valid,
  output logic                          ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  import uart_pkg::*;

  localparam int DIV   = baud_div(CLK_HZ, BAUD);
  localparam int CNT_W = $clog2(DIV);
  localparam int BIT_W = 4;

  if (!params_legal(CLK_HZ, BAUD, DATA_BITS, STOP_BITS, FIFO_DEPTH, PARITY_ODD)) begin : g_bad_params
    $error("uart_tx_fifo: illegal parameter combination");
  end

  tx_state_t            state, state_n;
  logic [CNT_W-1:0]     baud_cnt, baud_n;
  logic [BIT_W-1:0]     bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 tx_n;
  logic                 pop;
  logic                 bit_end;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign ready   = ~fifo_full;
  assign busy    = (state != IDLE);
  assign bit_end = (baud_cnt == CNT_W'(DIV - 1));

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .wdata (data),
    .push  (valid & ready),
    .pop   (pop),
    .rdata (fifo_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_bit;

  // Parity is taken from the word as it leaves the FIFO, before shifting destroys it.
  always_ff @(posedge clock) begin
    if (reset)    parity_bit <= 1'b0;
    else if (pop) parity_bit <= (^fifo_data) ^ (PARITY_ODD != 0);
  end
`endif

  // Next-state logic: tx is computed one clock early so the pin is a plain register.
  always_comb begin
    state_n = state;
    baud_n  = bit_end ? '0 : baud_cnt + CNT_W'(1);
    bit_n   = bit_cnt;
    shreg_n = shreg;
    tx_n    = tx;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        tx_n   = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_n = fifo_data;
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          bit_n   = '0;
          tx_n    = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            bit_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = parity_bit;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_n   = bit_cnt + BIT_W'(1);
            shreg_n = shreg >> 1;
            tx_n    = shreg[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          bit_n   = '0;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            bit_n = '0;
            if (!fifo_empty) begin
              pop     = 1'b1;
              shreg_n = fifo_data;
              state_n = START;
              tx_n    = 1'b0;
            end else begin
              state_n = IDLE;
              tx_n    = 1'b1;
            end
          end else begin
            bit_n = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  // State, counters, shift register and the registered line output.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
    end
  end

endmodule
